disk_req_arbiter: RTL and testbench
===================================

Name: disk_req_arbiter

Overview:
Shares one host disk-service channel (the sector/seek mailbox serviced by the host controller, plus its byte strobes) between two disk controllers, e.g. the nec765 FDC and a second drive controller. It takes level-held sector/seek requests, grants round-robin and issues one host command at a time. It routes data strobes to the granted requester, enforces a completion timeout, and returns done/error per requester.

Parameters:
TIMEOUT_CYCLES, 24'd12000000, clk cycles from host_cmd_valid rise to forced abort (0 = no timeout)
TO_WIDTH, 24, width of timeout counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 request, level, held until req0_done
req0_op  in  2  00 read, 01 write, 10 seek, 11 reserved
req0_cmd  in  17  {drive, head, track[6:0], sector[7:0]}
req0_done  out  1  one-cycle completion pulse
req0_err  out  1  error status, valid with req0_done, held until next grant to 0
req0_rd_stb  out  1  host read byte strobe routed to requester 0
req0_wr_stb  out  1  host write byte strobe routed to requester 0
req0_wr_data  in  8  write byte from requester 0
req1_*  (same set, requester 1)
host_cmd  out  32  {5'b0, grant_id, op[1:0], 7'b0, drive, head, track, sector}
host_cmd_valid  out  1  command pending, held until host_done or abort
host_done  in  1  one-cycle pulse, command finished
host_err  in  1  error flag, sampled with host_done
host_abort  out  1  one-cycle pulse on timeout
host_rd_stb  in  1  host delivering byte (data on host_rd_data, passed through unregistered)
host_wr_stb  in  1  host consuming write byte
host_wr_data  out  8  granted requester's wr_data, 8'h00 when none granted
busy  out  1  state != IDLE
stats  out  32  see Optional Feature

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, last_grant=1 (so requester 0 wins first), timeout counter 0, req*_err 0.
- States: IDLE -> ISSUE -> WAIT -> COMPLETE -> IDLE.
- IDLE: if one valid, grant it. If both valid, grant the one != last_grant. Latch op/cmd into host_cmd; next cycle ISSUE. Op 11: no host command; go to COMPLETE with err=1.
- ISSUE: host_cmd_valid<=1, counter cleared. Next cycle WAIT.
- WAIT: host_cmd_valid held. Counter increments each cycle.
  - host_done: host_cmd_valid<=0, err<=host_err, go to COMPLETE.
  - Counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): host_cmd_valid<=0, host_abort pulse, err<=1, COMPLETE.
  - host_done on the same cycle as expiry: host_done wins, no abort.
- COMPLETE: first cycle pulses reqN_done for granted id; last_grant<=id. Stay until granted reqN_valid==0, then IDLE. This prevents re-issue of a still-held level request.
- Strobe routing: host_rd_stb/host_wr_stb forwarded combinationally to granted requester only in WAIT. Strobes outside WAIT are dropped. Non-granted requester strobes always 0.
- Requester dropping valid during ISSUE/WAIT: command still completes, done still pulsed. Drop is not an abort.
- Latency: request to host_cmd_valid = 2 cycles; host_done to reqN_done = 1 cycle.
- host_cmd stable from ISSUE until IDLE.

Optional Feature:
DISK_ARB_STATS_EN:
- Defined: stats = {err_cnt[7:0], to_cnt[7:0], done1_cnt[7:0], done0_cnt[7:0]}.
  - doneN_cnt counts doneN pulses.
  - err_cnt counts done pulses with err=1.
  - to_cnt counts timeouts.
  - All saturate at 8'hFF; reset to 0.
- Undefined: stats tied to 32'h0, no counters synthesized.

Test Plan:
- req0 read {d0,h0,t5,s0xC1}, host_done 20 cycles later, host_err=0 -> host_cmd=32'h00000_05C1 form with id 0 and op 00, valid 2 cycles after req; req0_done 1 cycle after host_done, req0_err=0.
- req0 and req1 rise same cycle after reset -> req0 granted first. req1 granted after req0_valid drops, host_cmd[26]=1.
- req1 write, host_wr_stb pulses x512 -> req1_wr_stb pulses x512, req0_wr_stb 0, host_wr_data follows req1_wr_data.
- TIMEOUT_CYCLES=16, host silent -> host_abort at cycle 16 of WAIT, req0_done with req0_err=1; stats to_cnt=1 with DISK_ARB_STATS_EN.
- req0 holds valid after done -> no second host_cmd_valid until req0_valid low then high.
- rst asserted mid-WAIT -> host_cmd_valid and all done/stb outputs 0 immediately; after release req0 granted first.

Source files
------------

// File: rtl/disk_req_arbiter.sv
// disk_req_arbiter: round-robin share of one host disk-service channel between two controllers.
// Optional DISK_ARB_STATS_EN adds saturating done/timeout/error counters on stats.
module disk_req_arbiter #(
  parameter int TO_WIDTH = 24,
  parameter logic [TO_WIDTH-1:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [16:0] req0_cmd,
  output logic        req0_done,
  output logic        req0_err,
  output logic        req0_rd_stb,
  output logic        req0_wr_stb,
  input  logic [7:0]  req0_wr_data,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [16:0] req1_cmd,
  output logic        req1_done,
  output logic        req1_err,
  output logic        req1_rd_stb,
  output logic        req1_wr_stb,
  input  logic [7:0]  req1_wr_data,
  output logic [31:0] host_cmd,
  output logic        host_cmd_valid,
  input  logic        host_done,
  input  logic        host_err,
  output logic        host_abort,
  input  logic        host_rd_stb,
  input  logic        host_wr_stb,
  output logic [7:0]  host_wr_data,
  output logic        busy,
  output logic [31:0] stats
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;
  localparam logic [TO_WIDTH-1:0] TO_ONE = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0] TO_LAST = TIMEOUT_CYCLES - TO_ONE;
  localparam bit TO_EN = TIMEOUT_CYCLES != '0;
  state_t state, state_nx;
  logic gid, last_grant, fresh, err0, err1, any, pick, gvalid, expire;
  logic [1:0] pick_op;
  logic [16:0] pick_cmd;
  logic [TO_WIDTH-1:0] cnt;
  assign any = req0_valid | req1_valid;
  // With both requesting, the one not served last wins.
  assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign pick_op = pick ? req1_op : req0_op;
  assign pick_cmd = pick ? req1_cmd : req0_cmd;
  assign gvalid = gid ? req1_valid : req0_valid;
  assign expire = TO_EN && cnt == TO_LAST;
  assign busy = state != IDLE;
  assign req0_err = err0;
  assign req1_err = err1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !any ? IDLE : (pick_op == 2'b11 ? COMPLETE : ISSUE);
      ISSUE:    state_nx = WAIT;
      WAIT:     state_nx = (host_done || expire) ? COMPLETE : WAIT;
      COMPLETE: state_nx = gvalid ? COMPLETE : IDLE;
      default:  state_nx = IDLE;
    endcase
    host_abort = state == WAIT && expire && !host_done;
    req0_done = state == COMPLETE && fresh && !gid;
    req1_done = state == COMPLETE && fresh && gid;
    req0_rd_stb = state == WAIT && !gid && host_rd_stb;
    req1_rd_stb = state == WAIT && gid && host_rd_stb;
    req0_wr_stb = state == WAIT && !gid && host_wr_stb;
    req1_wr_stb = state == WAIT && gid && host_wr_stb;
    host_wr_data = state == IDLE ? 8'h00 : (gid ? req1_wr_data : req0_wr_data);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gid <= 1'b0;
      last_grant <= 1'b1;
      host_cmd <= '0;
      host_cmd_valid <= 1'b0;
      cnt <= '0;
      fresh <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      fresh <= state != COMPLETE && state_nx == COMPLETE;
      if (state == IDLE && any) begin
        gid <= pick;
        host_cmd <= {5'b0, pick, pick_op, 7'b0, pick_cmd};
        if (pick) err1 <= pick_op == 2'b11;
        else err0 <= pick_op == 2'b11;
      end
      if (state == ISSUE) begin
        host_cmd_valid <= 1'b1;
        cnt <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + TO_ONE;
        if (host_done || expire) begin
          host_cmd_valid <= 1'b0;
          if (gid) err1 <= host_done ? host_err : 1'b1;
          else err0 <= host_done ? host_err : 1'b1;
        end
      end
      if (state == COMPLETE && fresh) last_grant <= gid;
    end
`ifdef DISK_ARB_STATS_EN
  logic [7:0] done0_cnt, done1_cnt, to_cnt, err_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
      to_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (req0_done && done0_cnt != 8'hFF) done0_cnt <= done0_cnt + 8'd1;
      if (req1_done && done1_cnt != 8'hFF) done1_cnt <= done1_cnt + 8'd1;
      if (host_abort && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
      if ((req0_done || req1_done) && (gid ? err1 : err0) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  assign stats = {err_cnt, to_cnt, done1_cnt, done0_cnt};
`else
  assign stats = 32'h0;
`endif
endmodule

// File: tb/tb_disk_req_arbiter.sv
// tb_disk_req_arbiter: directed checks of grant order, latency, strobe routing, timeout and reset.
`timescale 1ns/1ns
module tb_disk_req_arbiter;
  localparam int HALF = 2000;
`ifdef DISK_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [16:0] req0_cmd = 0, req1_cmd = 0;
  logic [7:0] req0_wr_data = 0, req1_wr_data = 0;
  logic req0_done, req0_err, req0_rd_stb, req0_wr_stb;
  logic req1_done, req1_err, req1_rd_stb, req1_wr_stb;
  logic [31:0] host_cmd, stats;
  logic host_cmd_valid, host_abort, busy;
  logic host_done = 0, host_err = 0, host_rd_stb = 0, host_wr_stb = 0;
  logic [7:0] host_wr_data;
  int passed = 0, total = 0, n0 = 0, n1 = 0;
  always #HALF clk = ~clk;
  always @(posedge req0_wr_stb) n0++;
  always @(posedge req1_wr_stb) n1++;
  disk_req_arbiter #(.TO_WIDTH(24), .TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_cmd(req0_cmd), .req0_done(req0_done),
    .req0_err(req0_err), .req0_rd_stb(req0_rd_stb), .req0_wr_stb(req0_wr_stb), .req0_wr_data(req0_wr_data),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_cmd(req1_cmd), .req1_done(req1_done),
    .req1_err(req1_err), .req1_rd_stb(req1_rd_stb), .req1_wr_stb(req1_wr_stb), .req1_wr_data(req1_wr_data),
    .host_cmd(host_cmd), .host_cmd_valid(host_cmd_valid), .host_done(host_done), .host_err(host_err),
    .host_abort(host_abort), .host_rd_stb(host_rd_stb), .host_wr_stb(host_wr_stb),
    .host_wr_data(host_wr_data), .busy(busy), .stats(stats)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #1;
    check("rst_valid", host_cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd", host_cmd, 0);
    check("rst_stats", stats, 0);
    tick(2);
    rst = 0;
    tick();
    req0_op = 2'b00; req0_cmd = 17'h005C1; req0_valid = 1;
    tick();
    check("t1_lat1_valid", host_cmd_valid, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_valid", host_cmd_valid, 1);
    check("t1_cmd", host_cmd, 32'h000005C1);
    tick(5);
    host_done = 1;
    check("t1_early_done", req0_done, 0);
    tick();
    host_done = 0;
    check("t1_done", req0_done, 1);
    check("t1_err", req0_err, 0);
    check("t1_valid_off", host_cmd_valid, 0);
    tick();
    check("t1_done_pulse", req0_done, 0);
    check("t1_hold_busy", busy, 1);
    tick(3);
    check("t1_no_reissue", host_cmd_valid, 0);
    req0_valid = 0;
    tick();
    check("t1_idle", busy, 0);
    req0_valid = 1;
    tick(2);
    check("t1_reissue", host_cmd_valid, 1);
    host_done = 1;
    tick();
    host_done = 0; req0_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1; req1_valid = 1; req1_op = 2'b01; req1_cmd = 17'h18A07;
    tick(2);
    check("t2_first_id", host_cmd[26], 0);
    host_done = 1;
    tick();
    host_done = 0;
    check("t2_done0", req0_done, 1);
    check("t2_no_done1", req1_done, 0);
    tick(2);
    check("t2_req1_waits", host_cmd_valid, 0);
    req0_valid = 0;
    tick(3);
    check("t2_valid1", host_cmd_valid, 1);
    check("t2_cmd1", host_cmd, 32'h05018A07);
    req1_wr_data = 8'hA5;
    #1 check("t3_wdata_a5", host_wr_data, 8'hA5);
    for (int i = 0; i < 512; i++) begin
      host_wr_stb = 1; #1;
      host_wr_stb = 0; #1;
    end
    check("t3_wr_stb1_cnt", n1, 512);
    check("t3_wr_stb0_cnt", n0, 0);
    req1_wr_data = 8'h3C;
    host_rd_stb = 1;
    #1 check("t3_wdata_3c", host_wr_data, 8'h3C);
    check("t3_rd_stb1", req1_rd_stb, 1);
    check("t3_rd_stb0", req0_rd_stb, 0);
    host_rd_stb = 0;
    host_done = 1; host_err = 1;
    tick();
    host_done = 0; host_err = 0;
    check("t3_done1", req1_done, 1);
    check("t3_err1", req1_err, 1);
    check("t3_err0", req0_err, 0);
    req1_valid = 0;
    tick();
    check("t3_idle", busy, 0);
    check("t3_wdata_idle", host_wr_data, 0);
    host_rd_stb = 1; host_wr_stb = 1;
    #1 check("t3_idle_rd_drop", req0_rd_stb, 0);
    check("t3_idle_wr_drop", n1, 512);
    host_rd_stb = 0; host_wr_stb = 0;
    req0_op = 2'b00; req0_cmd = 17'h00203; req0_valid = 1;
    tick(2);
    check("t4_valid", host_cmd_valid, 1);
    tick(14);
    check("t4_no_abort_yet", host_abort, 0);
    tick();
    check("t4_abort", host_abort, 1);
    check("t4_valid_at_abort", host_cmd_valid, 1);
    tick();
    check("t4_abort_pulse", host_abort, 0);
    check("t4_done", req0_done, 1);
    check("t4_err", req0_err, 1);
    check("t4_valid_off", host_cmd_valid, 0);
    check("t4_stats", stats, STATS ? 32'h02010102 : 32'h0);
    req0_valid = 0;
    tick();
    req0_valid = 1;
    tick(2);
    req0_valid = 0;
    tick(15);
    host_done = 1;
    #1 check("t5_done_beats_abort", host_abort, 0);
    tick();
    host_done = 0;
    check("t5_done", req0_done, 1);
    check("t5_err", req0_err, 0);
    tick();
    check("t5_idle", busy, 0);
    check("t5_stats", stats, STATS ? 32'h02010103 : 32'h0);
    req1_op = 2'b11; req1_valid = 1;
    tick();
    check("t6_done", req1_done, 1);
    check("t6_err", req1_err, 1);
    check("t6_no_cmd", host_cmd_valid, 0);
    req1_valid = 0;
    tick();
    check("t6_idle", busy, 0);
    check("t6_stats", stats, STATS ? 32'h03010203 : 32'h0);
    req0_valid = 1;
    tick(2);
    host_rd_stb = 1;
    #1 check("t7_rd_stb", req0_rd_stb, 1);
    rst = 1;
    #1 check("t7_rst_valid", host_cmd_valid, 0);
    check("t7_rst_rd_stb", req0_rd_stb, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_err1", req1_err, 0);
    check("t7_rst_stats", stats, 0);
    host_rd_stb = 0; req1_op = 2'b00; req1_valid = 1;
    tick();
    rst = 0;
    tick(2);
    check("t7_first_id", host_cmd[26], 0);
    check("t7_valid", host_cmd_valid, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
